// File: rtl/reorder_pkg.sv
// -----------------------------------------------------------------------------
// reorder_pkg
// Shared types and helpers for the NTT output reorder controller.
//   state_t   : controller phase (WRITE = accepting result pairs, READ = draining)
//   bitrev()  : reverse the low 'width' bits of a value (width <= 32)
//   n_points(): transform size N = 1 << stages
// -----------------------------------------------------------------------------
package reorder_pkg;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } state_t;

    // Reverse the low 'width' bits of value; bits above 'width' come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < width) begin
                r[5'(width - 1 - i)] = value[5'(i)];
            end
        end
        return r;
    endfunction

    function automatic int unsigned n_points(input int unsigned stages);
        return 32'd1 << stages;
    endfunction

endpackage

// File: rtl/bit_reverse.sv
// -----------------------------------------------------------------------------
// bit_reverse
// Pure wire permutation: dout[i] = din[WIDTH-1-i]. No logic, no state.
//   WIDTH  : bus width
//   din    in  WIDTH  value to reverse
//   dout   out WIDTH  bit-reversed value
// -----------------------------------------------------------------------------
module bit_reverse #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_swap
        assign dout[i] = din[WIDTH-1-i];
    end

endmodule

// File: rtl/reorder_out.sv
// -----------------------------------------------------------------------------
// reorder_out
// Address and sequencing controller for the NTT output reorder buffer
// (N = 2^NUM_STAGES points). WRITE phase: N/2 result pairs are accepted, one
// per next_pair strobe, and each element of the current pair is given its
// natural-order buffer address. READ phase: the buffer is swept 0..N-1, one
// address per cycle, and out_done pulses once the sweep completes.
//
// Build option REORDER_OUT_BITREV_EN:
//   defined   - pairs arrive in bit-reversed order; write addresses are
//               bitrev(2k) / bitrev(2k+1)
//   undefined - pairs arrive in natural order; write addresses are 2k / 2k+1
//
// Ports
//   clk          in   1           rising-edge clock
//   reset        in   1           asynchronous active-low reset
//   next_pair    in   1           strobe: current pair written, advance
//   wr_addr_top  out  NUM_STAGES  write address, top element (from k, comb)
//   wr_addr_bot  out  NUM_STAGES  write address, bottom element (from k, comb)
//   rd_addr      out  NUM_STAGES  read address during READ, 0 otherwise
//   in_done      out  1           high while in READ (registered)
//   out_done     out  1           one-cycle pulse after address N-1 is read
// -----------------------------------------------------------------------------
module reorder_out
    import reorder_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  next_pair,
    output logic [NUM_STAGES-1:0] wr_addr_top,
    output logic [NUM_STAGES-1:0] wr_addr_bot,
    output logic [NUM_STAGES-1:0] rd_addr,
    output logic                  in_done,
    output logic                  out_done
);

    localparam int unsigned AW = NUM_STAGES;
    localparam int unsigned KW = NUM_STAGES - 1;
    localparam int unsigned N  = n_points(NUM_STAGES);

    localparam logic [KW-1:0] K_LAST  = KW'(N / 2 - 1);
    localparam logic [AW-1:0] RD_LAST = AW'(N - 1);

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic            out_done_d;
    logic            in_done_q;
    logic            out_done_q;
    logic [AW-1:0]   lin_top;
    logic [AW-1:0]   lin_bot;

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= WRITE;
            k_q        <= '0;
            rd_q       <= '0;
            in_done_q  <= 1'b0;
            out_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            rd_q       <= rd_d;
            in_done_q  <= (state_d == READ);
            out_done_q <= out_done_d;
        end
    end

    // Next-state, pair counter and read counter
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        rd_d       = rd_q;
        out_done_d = 1'b0;
        case (state_q)
            WRITE: begin
                if (next_pair) begin
                    // k wraps to 0 naturally after the last pair
                    k_d = k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        state_d = READ;
                        rd_d    = '0;
                    end
                end
            end
            READ: begin
                // Free-running sweep; next_pair is ignored here
                k_d  = '0;
                rd_d = rd_q + AW'(1);
                if (rd_q == RD_LAST) begin
                    state_d    = WRITE;
                    rd_d       = '0;
                    out_done_d = 1'b1;
                end
            end
            default: begin
                state_d = WRITE;
                k_d     = '0;
                rd_d    = '0;
            end
        endcase
    end

    // Linear element addresses of the current pair: 2k and 2k+1
    assign lin_top = {k_q, 1'b0};
    assign lin_bot = {k_q, 1'b1};

`ifdef REORDER_OUT_BITREV_EN
    bit_reverse #(.WIDTH(AW)) u_rev_top (
        .din  (lin_top),
        .dout (wr_addr_top)
    );

    bit_reverse #(.WIDTH(AW)) u_rev_bot (
        .din  (lin_bot),
        .dout (wr_addr_bot)
    );
`else
    assign wr_addr_top = lin_top;
    assign wr_addr_bot = lin_bot;
`endif

    // rd_q is held at 0 throughout WRITE, so it drives rd_addr directly
    assign rd_addr  = rd_q;
    assign in_done  = in_done_q;
    assign out_done = out_done_q;

endmodule

// File: tb/tb_reorder_out.sv
// -----------------------------------------------------------------------------
// tb_reorder_out
// Directed self-checking bench for reorder_out with NUM_STAGES = 4 (N = 16).
// Expected write-address tables follow the REORDER_OUT_BITREV_EN build option.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_reorder_out;

    logic       clk;
    logic       reset;
    logic       next_pair;
    logic [3:0] wr_addr_top;
    logic [3:0] wr_addr_bot;
    logic [3:0] rd_addr;
    logic       in_done;
    logic       out_done;

    int errors;
    int checks;

    logic [3:0] exp_top [8];
    logic [3:0] exp_bot [8];

    reorder_out #(.NUM_STAGES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .next_pair   (next_pair),
        .wr_addr_top (wr_addr_top),
        .wr_addr_bot (wr_addr_bot),
        .rd_addr     (rd_addr),
        .in_done     (in_done),
        .out_done    (out_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle strobe, from one falling edge to the next
    task automatic pulse_next();
        next_pair = 1'b1;
        @(negedge clk);
        next_pair = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        next_pair = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rd_addr !== 4'd0) begin errors++; $display("FAIL rst_rd got %0d want 0", rd_addr); end
        checks++; if (in_done !== 1'b0) begin errors++; $display("FAIL rst_in_done got %b want 0", in_done); end
        checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL rst_out_done got %b want 0", out_done); end
        checks++; if (wr_addr_top !== exp_top[0]) begin errors++; $display("FAIL rst_top got %0d want %0d", wr_addr_top, exp_top[0]); end
        checks++; if (wr_addr_bot !== exp_bot[0]) begin errors++; $display("FAIL rst_bot got %0d want %0d", wr_addr_bot, exp_bot[0]); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rd_addr !== 4'd0) begin errors++; $display("FAIL idle_rd got %0d want 0", rd_addr); end
        checks++; if (in_done !== 1'b0) begin errors++; $display("FAIL idle_in_done got %b want 0", in_done); end
        checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL idle_out_done got %b want 0", out_done); end
        checks++; if (wr_addr_top !== exp_top[0]) begin errors++; $display("FAIL idle_top got %0d want %0d", wr_addr_top, exp_top[0]); end
        checks++; if (wr_addr_bot !== exp_bot[0]) begin errors++; $display("FAIL idle_bot got %0d want %0d", wr_addr_bot, exp_bot[0]); end
    endtask

    // 8 strobes spaced 6 cycles apart; address table checked before each
    task automatic test_write_order();
        for (int p = 0; p < 8; p++) begin
            checks++; if (wr_addr_top !== exp_top[p]) begin errors++; $display("FAIL wr_top[%0d] got %0d want %0d", p, wr_addr_top, exp_top[p]); end
            checks++; if (wr_addr_bot !== exp_bot[p]) begin errors++; $display("FAIL wr_bot[%0d] got %0d want %0d", p, wr_addr_bot, exp_bot[p]); end
            checks++; if (in_done !== 1'b0) begin errors++; $display("FAIL wr_in_done[%0d] got %b want 0", p, in_done); end
            pulse_next();
            if (p < 7) repeat (5) @(negedge clk);
        end
    endtask

    // Entered right after the 8th strobe has been captured
    task automatic test_read_phase();
        for (int i = 0; i < 16; i++) begin
            checks++; if (in_done !== 1'b1) begin errors++; $display("FAIL rd_in_done[%0d] got %b want 1", i, in_done); end
            checks++; if (rd_addr !== 4'(i)) begin errors++; $display("FAIL rd_addr[%0d] got %0d want %0d", i, rd_addr, i); end
            checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL rd_out_done[%0d] got %b want 0", i, out_done); end
            @(negedge clk);
        end
        checks++; if (out_done !== 1'b1) begin errors++; $display("FAIL done_pulse got %b want 1", out_done); end
        checks++; if (in_done !== 1'b0) begin errors++; $display("FAIL done_in_done got %b want 0", in_done); end
        checks++; if (rd_addr !== 4'd0) begin errors++; $display("FAIL done_rd got %0d want 0", rd_addr); end
        checks++; if (wr_addr_top !== exp_top[0]) begin errors++; $display("FAIL done_top got %0d want %0d", wr_addr_top, exp_top[0]); end
        @(negedge clk);
        checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL done_width got %b want 0", out_done); end
        checks++; if (wr_addr_bot !== exp_bot[0]) begin errors++; $display("FAIL done_bot got %0d want %0d", wr_addr_bot, exp_bot[0]); end
    endtask

    // Adjacent strobes, then next_pair held high through READ (ignored)
    task automatic test_ignore_during_read();
        for (int c = 0; c < 8; c++) begin
            checks++; if (wr_addr_top !== exp_top[c]) begin errors++; $display("FAIL adj_top[%0d] got %0d want %0d", c, wr_addr_top, exp_top[c]); end
            checks++; if (wr_addr_bot !== exp_bot[c]) begin errors++; $display("FAIL adj_bot[%0d] got %0d want %0d", c, wr_addr_bot, exp_bot[c]); end
            next_pair = 1'b1;
            @(negedge clk);
        end
        for (int i = 0; i < 16; i++) begin
            checks++; if (rd_addr !== 4'(i)) begin errors++; $display("FAIL ign_rd[%0d] got %0d want %0d", i, rd_addr, i); end
            checks++; if (wr_addr_top !== exp_top[0]) begin errors++; $display("FAIL ign_top[%0d] got %0d want %0d", i, wr_addr_top, exp_top[0]); end
            next_pair = (i < 15);
            @(negedge clk);
        end
        checks++; if (out_done !== 1'b1) begin errors++; $display("FAIL ign_done got %b want 1", out_done); end
        checks++; if (wr_addr_top !== exp_top[0]) begin errors++; $display("FAIL ign_after_top got %0d want %0d", wr_addr_top, exp_top[0]); end
        @(negedge clk);
        checks++; if (wr_addr_bot !== exp_bot[0]) begin errors++; $display("FAIL ign_idle_bot got %0d want %0d", wr_addr_bot, exp_bot[0]); end
    endtask

    // next_pair held high continuously: 13 frames of 8 writes + 16 reads,
    // with the out_done cycle accepting pair 0 of the following frame
    task automatic test_back_to_back();
        int t;
        int f;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 13 * 24; c++) begin
            t = c % 24;
            f = c / 24;
            if (t < 8) begin
                checks++; if (wr_addr_top !== exp_top[t]) begin errors++; $display("FAIL b2b_top f%0d p%0d got %0d want %0d", f, t, wr_addr_top, exp_top[t]); end
                checks++; if (wr_addr_bot !== exp_bot[t]) begin errors++; $display("FAIL b2b_bot f%0d p%0d got %0d want %0d", f, t, wr_addr_bot, exp_bot[t]); end
                checks++; if (in_done !== 1'b0) begin errors++; $display("FAIL b2b_in_done f%0d c%0d got %b want 0", f, t, in_done); end
                checks++; if (out_done !== (t == 0 && f > 0)) begin errors++; $display("FAIL b2b_out_done f%0d c%0d got %b want %b", f, t, out_done, (t == 0 && f > 0)); end
            end else begin
                checks++; if (rd_addr !== 4'(t - 8)) begin errors++; $display("FAIL b2b_rd f%0d c%0d got %0d want %0d", f, t, rd_addr, t - 8); end
                checks++; if (in_done !== 1'b1) begin errors++; $display("FAIL b2b_in_done f%0d c%0d got %b want 1", f, t, in_done); end
                checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL b2b_out_done f%0d c%0d got %b want 0", f, t, out_done); end
            end
            next_pair = 1'b1;
            @(negedge clk);
        end
        next_pair = 1'b0;
        checks++; if (out_done !== 1'b1) begin errors++; $display("FAIL b2b_final_done got %b want 1", out_done); end
        checks++; if (wr_addr_top !== exp_top[0]) begin errors++; $display("FAIL b2b_final_top got %0d want %0d", wr_addr_top, exp_top[0]); end
        @(negedge clk);
    endtask

    // Reset at k=5 and during READ; next frame restarts cleanly
    task automatic test_reset_mid();
        for (int p = 0; p < 5; p++) pulse_next();
        checks++; if (wr_addr_top !== exp_top[5]) begin errors++; $display("FAIL mid_top_k5 got %0d want %0d", wr_addr_top, exp_top[5]); end
        #2 reset = 1'b0;
        #1;
        checks++; if (wr_addr_top !== exp_top[0]) begin errors++; $display("FAIL mid_rst_top got %0d want %0d", wr_addr_top, exp_top[0]); end
        checks++; if (wr_addr_bot !== exp_bot[0]) begin errors++; $display("FAIL mid_rst_bot got %0d want %0d", wr_addr_bot, exp_bot[0]); end
        checks++; if (in_done !== 1'b0) begin errors++; $display("FAIL mid_rst_in_done got %b want 0", in_done); end
        checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL mid_rst_out_done got %b want 0", out_done); end
        @(negedge clk);
        reset = 1'b1;
        for (int p = 0; p < 8; p++) begin
            checks++; if (wr_addr_top !== exp_top[p]) begin errors++; $display("FAIL post_top[%0d] got %0d want %0d", p, wr_addr_top, exp_top[p]); end
            checks++; if (wr_addr_bot !== exp_bot[p]) begin errors++; $display("FAIL post_bot[%0d] got %0d want %0d", p, wr_addr_bot, exp_bot[p]); end
            pulse_next();
        end
        for (int i = 0; i < 16; i++) begin
            checks++; if (rd_addr !== 4'(i)) begin errors++; $display("FAIL post_rd[%0d] got %0d want %0d", i, rd_addr, i); end
            @(negedge clk);
        end
        checks++; if (out_done !== 1'b1) begin errors++; $display("FAIL post_done got %b want 1", out_done); end
        @(negedge clk);
        // Reset three cycles into READ
        for (int p = 0; p < 8; p++) pulse_next();
        repeat (3) @(negedge clk);
        checks++; if (rd_addr !== 4'd3) begin errors++; $display("FAIL rdrst_pre_rd got %0d want 3", rd_addr); end
        #2 reset = 1'b0;
        #1;
        checks++; if (in_done !== 1'b0) begin errors++; $display("FAIL rdrst_in_done got %b want 0", in_done); end
        checks++; if (rd_addr !== 4'd0) begin errors++; $display("FAIL rdrst_rd got %0d want 0", rd_addr); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++; if (out_done !== 1'b0 || in_done !== 1'b0) begin errors++; $display("FAIL rdrst_quiet[%0d] got done=%b in=%b want 0 0", i, out_done, in_done); end
            @(negedge clk);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b0;
        next_pair = 1'b0;
`ifdef REORDER_OUT_BITREV_EN
        exp_top = '{4'd0, 4'd4, 4'd2,  4'd6,  4'd1, 4'd5,  4'd3,  4'd7};
        exp_bot = '{4'd8, 4'd12, 4'd10, 4'd14, 4'd9, 4'd13, 4'd11, 4'd15};
`else
        exp_top = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14};
        exp_bot = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15};
`endif
        test_reset();
        test_write_order();
        test_read_phase();
        test_ignore_during_read();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reorder_out.md
# reorder_out

Address and sequencing controller for the NTT output reorder buffer, parameterised by the number of butterfly stages (N = 2^NUM_STAGES points). It sits between the last butterfly stage and the output port. In the write phase it accepts N/2 result pairs and gives the natural-order buffer address for each element of the pair. In the read phase it sweeps the buffer in natural order and signals completion.

## Interface
- NUM_STAGES, default 4: log2 of transform size N; sets the width of all address ports.
- clk  in  1  single clock for the block, rising-edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- next_pair  in  1  one-cycle strobe: the pair currently addressed is being written; advance to the next pair.
- wr_addr_top  out  NUM_STAGES  buffer write address for the top element of the current pair.
- wr_addr_bot  out  NUM_STAGES  buffer write address for the bottom element of the current pair.
- rd_addr  out  NUM_STAGES  buffer read address; valid during the read phase, 0 otherwise.
- in_done  out  1  level; high while the buffer is full and being read out.
- out_done  out  1  one-cycle pulse; the final element (address N-1) has been read.

## Operation
- Two states: WRITE and READ.
  - Pair counter k: NUM_STAGES-1 bits, range 0..N/2-1.
  - Read counter: NUM_STAGES bits.
- WRITE state:
  - Address mapping with REORDER_OUT_BITREV_EN defined: wr_addr_top = bitrev(2k), wr_addr_bot = bitrev(2k+1). Bit reversal is over NUM_STAGES bits.
  - Address mapping without the macro: wr_addr_top = 2k, wr_addr_bot = 2k+1.
  - wr_addr_* are combinational from k and are valid in every WRITE cycle.
  - When next_pair=1, k increments at the clock edge.
  - When next_pair=1 and k = N/2-1: k wraps to 0, state goes to READ, read counter = 0.
- READ state:
  - rd_addr = read counter; it increments every cycle with no handshake.
  - When rd_addr = N-1: state goes to WRITE, read counter goes to 0, and out_done pulses.
  - next_pair is ignored; upstream must stall during READ. k holds 0 and wr_addr_* show the k=0 values.
- in_done = (state == READ), registered.
- out_done is a registered pulse. It is high exactly one cycle: the first WRITE cycle after READ.
- All counters wrap modulo their width; no overflow flags.

## Timing
- Reset values:
  - state WRITE, k=0, rd_addr=0, in_done=0, out_done=0.
  - wr_addr_top=0.
  - wr_addr_bot=N/2 with the macro, 1 without.
- Write latency: address for pair k+1 appears the cycle after the next_pair strobe for pair k.
- The READ phase lasts exactly N cycles:
  - in_done rises in the cycle after the last next_pair.
  - in_done falls in the same cycle out_done rises.
- A next_pair in the out_done cycle is accepted as pair 0 of the next frame. Back-to-back frames need no idle cycle.
- Consecutive next_pair strobes on adjacent cycles are each counted.
- Reset asserted mid-frame: immediate return to reset values. A partial frame is discarded; no out_done pulse.

## Configuration
- REORDER_OUT_BITREV_EN:
  - Defined: pairs arrive in bit-reversed order (DIF output) and write addresses are bit-reversed.
  - Undefined: pairs arrive in natural order and write addresses are linear 2k / 2k+1.
- Read sequencing is identical in both builds.

## Structure
- Shared package reorder_pkg holds:
  - the state enum {WRITE, READ};
  - a parameterised bitrev function over NUM_STAGES bits;
  - the N = 1 << NUM_STAGES constant helper.
- One natural sub-module: bit_reverse (pure combinational wire permutation, parameter WIDTH). It is instantiated twice for top and bottom addresses when the macro is defined.

## Test plan
All scenarios use NUM_STAGES=4 (N=16).
- Reset held low -> rd_addr=0, in_done=0, out_done=0, wr_addr_top=0, wr_addr_bot=8 (macro defined). Release reset -> outputs unchanged until next_pair.
- Macro defined, 8 strobes spaced 6 cycles apart -> (top,bot) pairs in order:
  - (0,8), (4,12), (2,10), (6,14);
  - (1,9), (5,13), (3,11), (7,15).
- Macro undefined, same stimulus -> pairs (0,1), (2,3) … (14,15).
- After the 8th strobe -> in_done high 16 cycles, rd_addr 0..15 one per cycle. out_done is high exactly one cycle, when in_done falls; rd_addr then returns to 0.
- next_pair pulses during READ -> ignored. After out_done, the first strobe yields pair 0 addresses and the next frame completes normally. This must hold over 100 strobes with no drift.
- Reset asserted at k=5 -> k, in_done and out_done clear immediately. The next frame starts from pair 0.
